muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage and consumes the same register operands (srca/srcb). The ALU's mfhi/mflo paths read its hi/lo outputs.
- Replaces single-cycle 32x32 multiplication with a 32-iteration engine.
- Control stalls the PC and register write while busy is high.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits.
- CNT_W, 6: iteration counter width; must hold values 0..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  single-cycle request, sampled only in IDLE
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- b  in  WIDTH  rt operand: multiplier or divisor
- flush  in  1  abort the in-flight operation
- busy  out  1  high while an operation is in flight; control stalls on it
- done  out  1  one-cycle pulse in the final cycle of a mul/div
- hi  out  WIDTH  HI register, always readable
- lo  out  WIDTH  LO register, always readable

Behaviour:
- Reset (asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation with no update.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start with op 0-3: latch a, b and op; record operand signs; load the magnitude operands (absolute value for signed ops); counter=WIDTH; go to CALC.
  - start with op 4 or 5: write a into hi (op 4) or lo (op 5) at that clock edge; stay in IDLE; busy stays 0; done stays 0.
  - start with op 6 or 7: ignored.
- CALC, one step per cycle, counter decrements:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter reaching 0 moves to FINISH.
- FINISH, one cycle, done=1:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Multiply result: hi=upper WIDTH bits, lo=lower WIDTH bits.
  - Divide result: lo=quotient, hi=remainder.
  - hi/lo are written at the FINISH edge; go to IDLE.
- Timing for start accepted at cycle N:
  - busy=1 in cycles N+1 through N+33.
  - done=1 in cycle N+33 only.
  - New hi/lo visible from cycle N+34.
  - busy is registered and has no combinational path from start.
- Divide by zero (DIV or DIVU, b=0): full latency still applies; lo=all ones, hi=a unchanged (raw bits, both signednesses).
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: ignored, including MTHI/MTLO; control guarantees it never issues one.
- flush in CALC or FINISH: return to IDLE at the next edge; hi/lo unchanged; done suppressed (even in FINISH).
- flush in IDLE: blocks any start in the same cycle.
- flush has priority over all other transitions; reset has priority over flush.
- All arithmetic is modulo 2^WIDTH per half. The counter never wraps: it is used only in CALC and is reloaded on entry.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - state encoding (IDLE, CALC, FINISH).
  - The control unit imports the same op constants.
- Sub-module muldiv_iter: unsigned single-step engine.
  - Combinational next-step logic for shift-add and shift-subtract on accumulator {rem/hi, quo/lo}.
  - The parent owns the FSM, counter, sign handling and hi/lo registers.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at N -> busy high N+1..N+33; done only at N+33; hi=0xFFFFFFFE, lo=0x00000001 from N+34.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=5, b=0 -> after 34 cycles lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 -> hi=0x1234 next cycle, busy never rises. During a later MULTU, a start with MTLO is ignored and lo comes only from the product.
- MULTU 3x4 with flush at N+10 -> busy=0 at N+11, no done, hi/lo retain prior values. A separate run with reset asserted at N+5 -> hi=lo=0 and busy=0 before the next clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
// The control unit imports the same op constants to drive the op field.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned single-step engine: one shift-add (mul) or restoring shift-subtract (div)
// on the {hi/rem, lo/quo} accumulator. Purely combinational; the parent sequences it.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = '0;
    if (is_div) begin
      // Borrow out of the W+1-bit trial means the divisor did not fit: restore.
      if (!diff[WIDTH])
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO owning the HI/LO pair.
// 33 busy cycles per mul/div (32 steps + sign fix-up); starts while busy are dropped.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   opnd, a_raw, a_mag, b_mag;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic               accept, op_signed;

  assign accept    = (state == ST_IDLE) && start && !flush;
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign busy      = (state != ST_IDLE);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      ST_IDLE:   if (accept && !op[2]) state_n = ST_CALC;
      ST_CALC: begin
        if (flush)                    state_n = ST_IDLE;
        else if (cnt == CNT_W'(1))    state_n = ST_FINISH;
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
        done    = !flush;
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  // Sign fix-up applied in FINISH; divide-by-zero returns the raw dividend in hi.
  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_n;
      if (accept && !op[2]) begin
        is_div   <= op[1];
        a_raw    <= a;
        neg_res  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem  <= op_signed && a[WIDTH-1];
        div_zero <= (b == '0);
        acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        opnd     <= op[1] ? b_mag : a_mag;
        cnt      <= CNT_W'(WIDTH);
      end
      if (accept && op == OP_MTHI) hi <= a;
      if (accept && op == OP_MTLO) lo <= a;
      if (state == ST_CALC) begin
        acc <= acc_next;
        cnt <= cnt - CNT_W'(1);
      end
      if (done) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases then random mul/div traffic
// scored against a 64-bit arithmetic model of HI/LO.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} as architecturally defined for ops 0..3.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    case (o)
      OP_MULT:  res = sx * sy;
      OP_MULTU: res = ux * uy;
      OP_DIV, OP_DIVU: begin
        if (y == 0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == OP_DIV) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {ux[31:0] % uy[31:0], ux[31:0] / uy[31:0]};
        end
      end
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue a mul/div; optionally flush at cycle N+flush_at or issue MTLO at N+mt_at.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at, input int mt_at, input string tag);
    logic [63:0] exp;
    exp = (flush_at == 0) ? ref_result(o, x, y) : {m_hi, m_lo};
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    for (int k = 1; k <= 33; k++) begin
      if (k == flush_at) flush = 1'b1;
      if (k == mt_at) begin start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF; end
      #1;
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " done"}, done, (k == 33 && flush_at == 0));
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      if (k == flush_at) break;
    end
    #1;
    check({tag, " busy end"}, busy, 1'b0);
    check({tag, " done end"}, done, 1'b0);
    check({tag, " hi"}, hi, exp[63:32]);
    check({tag, " lo"}, lo, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  // Single-cycle command in IDLE: MTHI/MTLO, no-op codes, or a start blocked by flush.
  task automatic idle_cmd(input logic [2:0] o, input logic [31:0] x, input logic fl,
                          input string tag);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = 32'h3; flush = fl;
    #1;
    check({tag, " busy same"}, busy, 1'b0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    if (!fl && o == OP_MTHI) m_hi = x;
    if (!fl && o == OP_MTLO) m_lo = x;
    #1;
    check({tag, " busy next"}, busy, 1'b0);
    check({tag, " done next"}, done, 1'b0);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("rst mid busy", busy, 1'b0);
    check("rst mid done", done, 1'b0);
    check("rst mid hi", hi, m_hi);
    check("rst mid lo", lo, m_lo);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("rst after busy", busy, 1'b0);
    check("rst after hi", hi, m_hi);
    check("rst after lo", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          rf;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu max");
    check("multu max hi const", hi, 32'hFFFF_FFFE);
    check("multu max lo const", lo, 32'h0000_0001);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         0, 0, "mult neg");
    check("mult neg lo const", lo, 32'hFFFF_FFEB);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, "mult minsq");
    check("mult minsq hi const", hi, 32'h4000_0000);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, "div neg");
    check("div neg lo const", lo, 32'hFFFF_FFFD);
    run_op(OP_DIVU,  32'd7,         32'd2,         0, 0, "divu");
    run_op(OP_DIVU,  32'd5,         32'd0,         0, 0, "divu zero");
    check("divu zero hi const", hi, 32'd5);
    run_op(OP_DIV,   32'h8000_0005, 32'd0,         0, 0, "div zero");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div ovf");
    check("div ovf lo const", lo, 32'h8000_0000);

    idle_cmd(OP_MTHI, 32'h0000_1234, 1'b0, "mthi");
    idle_cmd(OP_MTLO, 32'hCAFE_0001, 1'b0, "mtlo");
    idle_cmd(3'd6,    32'h5555_5555, 1'b0, "nop6");
    idle_cmd(3'd7,    32'hAAAA_AAAA, 1'b0, "nop7");
    idle_cmd(OP_MTHI, 32'h7777_7777, 1'b1, "mthi flushed");
    idle_cmd(OP_MULTU, 32'h3,        1'b1, "multu flushed");
    run_op(OP_MULTU, 32'h0001_0003, 32'h0002_0005, 0, 10, "multu mtlo busy");

    run_op(OP_MULTU, 32'd3, 32'd4, 10, 0, "flush calc");
    run_op(OP_DIV,   32'd100, 32'd7, 33, 0, "flush finish");
    run_op(OP_MULT,  32'd9, 32'd9, 1, 0, "flush first");

    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = pick();
      ry = pick();
      rf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 33)) : 0;
      run_op(ro, rx, ry, rf, 0, "rand");
      if ($urandom_range(0, 5) == 0)
        idle_cmd(3'($urandom_range(4, 5)), $urandom, 1'b0, "rand mt");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
